// File: rtl/video_block_track.sv
// rtl/video_block_track.sv - moving-block video sink: resolution check, block bbox, motion; option macro VBT_COLOR_TOL_EN
module video_block_track #(
  parameter int          H_DISP           = 1920,
  parameter int          V_DISP           = 1080,
  parameter bit          VS_POL           = 1'b1,
  parameter logic [23:0] MOVE_BLOCK_COLOR = 24'hffc0cb,
  parameter int          COLOR_TOL        = 8
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  output logic        frame_valid,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic        fmt_err,
  output logic        blk_found,
  output logic [10:0] blk_x_min,
  output logic [10:0] blk_x_max,
  output logic [10:0] blk_y_min,
  output logic [10:0] blk_y_max,
  output logic [11:0] blk_dx,
  output logic [11:0] blk_dy
);

  localparam logic [10:0] CNT_MAX = 11'h7ff;

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  state_t      state, state_nx;
  logic        vs_act_r, vs_act_d, de_r, de_d, hs_unused_r;
  logic [23:0] rgb_r;
  logic        vs_edge, de_fall, pix_match;
  logic [10:0] x_cnt, y_cnt;

  logic [10:0] h_acc, v_acc, xmin_acc, xmax_acc, ymin_acc, ymax_acc;
  logic        err_acc, found_acc;
  logic [10:0] h_nx, v_nx, xmin_nx, xmax_nx, ymin_nx, ymax_nx;
  logic        err_nx, found_nx;

  logic        prev_found;
  logic [10:0] prev_x, prev_y;

  // Input register stage; vs is reduced to "active level" before edge detection
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      vs_act_r    <= 1'b0;
      vs_act_d    <= 1'b0;
      de_r        <= 1'b0;
      de_d        <= 1'b0;
      rgb_r       <= '0;
      hs_unused_r <= 1'b0;
    end else begin
      vs_act_r    <= (video_vs == VS_POL);
      vs_act_d    <= vs_act_r;
      de_r        <= video_de;
      de_d        <= de_r;
      rgb_r       <= video_rgb;
      hs_unused_r <= video_hs;
    end
  end

  assign vs_edge = vs_act_r & ~vs_act_d;
  assign de_fall = de_d & ~de_r;

`ifdef VBT_COLOR_TOL_EN
  function automatic logic chan_ok(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = ({1'b0, a} >= {1'b0, b}) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return (d <= 9'(COLOR_TOL));
  endfunction

  assign pix_match = de_r
                   && chan_ok(rgb_r[23:16], MOVE_BLOCK_COLOR[23:16])
                   && chan_ok(rgb_r[15:8],  MOVE_BLOCK_COLOR[15:8])
                   && chan_ok(rgb_r[7:0],   MOVE_BLOCK_COLOR[7:0]);
`else
  localparam int color_tol_unused = COLOR_TOL;
  assign pix_match = de_r && (rgb_r == MOVE_BLOCK_COLOR);
`endif

  // Pixel column and line counters, saturating so oversized frames never wrap
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (de_fall)
        x_cnt <= '0;
      else if (de_r && x_cnt != CNT_MAX)
        x_cnt <= x_cnt + 11'd1;
      if (vs_edge)
        y_cnt <= '0;
      else if (de_fall && y_cnt != CNT_MAX)
        y_cnt <= y_cnt + 11'd1;
    end
  end

  // Frame state: IDLE until the first full frame starts, REPORT lasts one cycle
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vs_edge) state_nx = ACTIVE;
      ACTIVE:  if (vs_edge) state_nx = REPORT;
      REPORT:  state_nx = ACTIVE;
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator update; outside ACTIVE the base is a fresh frame so a pixel in
  // the REPORT cycle lands in the new frame
  always_comb begin
    h_nx     = h_acc;
    v_nx     = v_acc;
    err_nx   = err_acc;
    found_nx = found_acc;
    xmin_nx  = xmin_acc;
    xmax_nx  = xmax_acc;
    ymin_nx  = ymin_acc;
    ymax_nx  = ymax_acc;
    if (state != ACTIVE) begin
      h_nx     = '0;
      v_nx     = '0;
      err_nx   = 1'b0;
      found_nx = 1'b0;
      xmin_nx  = '0;
      xmax_nx  = '0;
      ymin_nx  = '0;
      ymax_nx  = '0;
    end
    if (de_fall) begin
      if (v_nx == '0)
        h_nx = x_cnt;
      else if (x_cnt != h_nx)
        err_nx = 1'b1;
      if (v_nx != CNT_MAX)
        v_nx = v_nx + 11'd1;
    end
    if (pix_match) begin
      if (!found_nx) begin
        xmin_nx = x_cnt;
        xmax_nx = x_cnt;
        ymin_nx = y_cnt;
        ymax_nx = y_cnt;
      end else begin
        if (x_cnt < xmin_nx) xmin_nx = x_cnt;
        if (x_cnt > xmax_nx) xmax_nx = x_cnt;
        if (y_cnt < ymin_nx) ymin_nx = y_cnt;
        if (y_cnt > ymax_nx) ymax_nx = y_cnt;
      end
      found_nx = 1'b1;
    end
  end

  // Accumulator registers
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      h_acc     <= '0;
      v_acc     <= '0;
      err_acc   <= 1'b0;
      found_acc <= 1'b0;
      xmin_acc  <= '0;
      xmax_acc  <= '0;
      ymin_acc  <= '0;
      ymax_acc  <= '0;
    end else begin
      h_acc     <= h_nx;
      v_acc     <= v_nx;
      err_acc   <= err_nx;
      found_acc <= found_nx;
      xmin_acc  <= xmin_nx;
      xmax_acc  <= xmax_nx;
      ymin_acc  <= ymin_nx;
      ymax_acc  <= ymax_nx;
    end
  end

  // Result latch, motion against the previously reported frame
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      frame_valid <= 1'b0;
      h_active    <= '0;
      v_active    <= '0;
      fmt_err     <= 1'b0;
      blk_found   <= 1'b0;
      blk_x_min   <= '0;
      blk_x_max   <= '0;
      blk_y_min   <= '0;
      blk_y_max   <= '0;
      blk_dx      <= '0;
      blk_dy      <= '0;
      prev_found  <= 1'b0;
      prev_x      <= '0;
      prev_y      <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (state == REPORT) begin
        frame_valid <= 1'b1;
        h_active    <= h_acc;
        v_active    <= v_acc;
        fmt_err     <= err_acc || (h_acc != 11'(H_DISP)) || (v_acc != 11'(V_DISP));
        blk_found   <= found_acc;
        blk_x_min   <= xmin_acc;
        blk_x_max   <= xmax_acc;
        blk_y_min   <= ymin_acc;
        blk_y_max   <= ymax_acc;
        if (found_acc && prev_found) begin
          blk_dx <= {1'b0, xmin_acc} - {1'b0, prev_x};
          blk_dy <= {1'b0, ymin_acc} - {1'b0, prev_y};
        end else begin
          blk_dx <= '0;
          blk_dy <= '0;
        end
        prev_found <= found_acc;
        prev_x     <= xmin_acc;
        prev_y     <= ymin_acc;
      end
    end
  end

endmodule

// File: tb/tb_video_block_track.sv
// tb/tb_video_block_track.sv - randomized scoreboard bench for video_block_track
module tb_video_block_track;
  localparam int          HD   = 64;
  localparam int          VD   = 32;
  localparam int          HBL  = 8;
  localparam logic [23:0] BLK  = 24'hffc0cb;
  localparam logic [23:0] NEAR = 24'hffc2c9;
  localparam int          TOL  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [23:0] rgb = '0;
  logic        frame_valid, fmt_err, blk_found;
  logic [10:0] h_active, v_active, blk_x_min, blk_x_max, blk_y_min, blk_y_max;
  logic [11:0] blk_dx, blk_dy;

  video_block_track #(.H_DISP(HD), .V_DISP(VD), .VS_POL(1'b1),
                      .MOVE_BLOCK_COLOR(BLK), .COLOR_TOL(TOL)) dut (
    .pixel_clk(clk), .sys_rst(rst), .video_hs(hs), .video_vs(vs), .video_de(de),
    .video_rgb(rgb), .frame_valid(frame_valid), .h_active(h_active), .v_active(v_active),
    .fmt_err(fmt_err), .blk_found(blk_found), .blk_x_min(blk_x_min), .blk_x_max(blk_x_max),
    .blk_y_min(blk_y_min), .blk_y_max(blk_y_max), .blk_dx(blk_dx), .blk_dy(blk_dy));

  always #5 clk = ~clk;

  typedef struct {
    int h, v, fmt, found, xmin, xmax, ymin, ymax, dx, dy;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, vs_cyc = 0;

  // frame descriptor
  int f_lines, f_short, f_short_len, f_blk, f_bx, f_by, f_bw, f_bh, f_nx, f_ny, f_rst;
  // previous reported frame, as the model sees it
  int m_prev_found = 0, m_prev_x = 0, m_prev_y = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit model_match(input logic [23:0] c);
`ifdef VBT_COLOR_TOL_EN
    return absd(int'(c[23:16]), 255) <= TOL && absd(int'(c[15:8]), 192) <= TOL
        && absd(int'(c[7:0]), 203) <= TOL;
`else
    return c == BLK;
`endif
  endfunction

  function automatic logic [23:0] color_at(input int x, input int y);
    if (x == f_nx && y == f_ny) return NEAR;
    if (f_blk != 0 && x >= f_bx && x < f_bx + f_bw && y >= f_by && y < f_by + f_bh) return BLK;
    return 24'h000000;
  endfunction

  function automatic int line_len(input int y);
    return (y == f_short) ? f_short_len : HD;
  endfunction

  task automatic model_frame(output exp_t e);
    e = '{default: 0};
    e.v = f_lines;
    e.h = (f_lines > 0) ? line_len(0) : 0;
    e.fmt = (e.h != HD || e.v != VD) ? 1 : 0;
    for (int y = 0; y < f_lines; y++) begin
      if (line_len(y) != e.h) e.fmt = 1;
      for (int x = 0; x < line_len(y); x++) begin
        if (model_match(color_at(x, y))) begin
          if (e.found == 0) begin
            e.xmin = x; e.xmax = x; e.ymin = y; e.ymax = y; e.found = 1;
          end else begin
            if (x < e.xmin) e.xmin = x;
            if (x > e.xmax) e.xmax = x;
            if (y < e.ymin) e.ymin = y;
            if (y > e.ymax) e.ymax = y;
          end
        end
      end
    end
    if (e.found != 0 && m_prev_found != 0) begin
      e.dx = e.xmin - m_prev_x;
      e.dy = e.ymin - m_prev_y;
    end
    m_prev_found = e.found;
    m_prev_x = e.xmin;
    m_prev_y = e.ymin;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0;
      rgb = ($urandom_range(0, 3) == 0) ? BLK : 24'($urandom);
    end
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vs = 1'b1;
    vs_cyc = cyc + 1;
    idle(1);
    @(negedge clk);
    vs = 1'b0;
  endtask

  task automatic set_frame(input int lines, input int blk, input int bx, input int by);
    f_lines = lines; f_blk = blk; f_bx = bx; f_by = by; f_bw = 8; f_bh = 8;
    f_short = -1; f_short_len = HD; f_nx = -1; f_ny = -1; f_rst = -1;
  endtask

  task automatic send_frame();
    exp_t e;
    bit   ok = 1'b1;
    logic [23:0] c;
    vs_pulse();
    idle(4);
    for (int y = 0; y < f_lines; y++) begin
      if (y == f_rst) begin
        rst = 1'b1;
        idle(3);
        chk("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_h_active", int'(h_active), 0);
        chk("rst_blk_found", int'(blk_found), 0);
        chk("rst_blk_x_min", int'(blk_x_min), 0);
        chk("rst_blk_dx", int'(blk_dx), 0);
        rst = 1'b0;
        ok = 1'b0;
        m_prev_found = 0;
      end
      for (int x = 0; x < line_len(y); x++) begin
        @(negedge clk);
        de = 1'b1;
        c = color_at(x, y);
        rgb = (c == 24'h000000) ? (24'($urandom) & 24'h7fffff) : c;
      end
      idle(HBL);
    end
    idle(2);
    if (ok) begin
      model_frame(e);
      q.push_back(e);
    end
  endtask

  // Scoreboard monitor: pops one expectation per frame_valid pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - vs_cyc, 2);
          chk("h_active", int'(h_active), e.h);
          chk("v_active", int'(v_active), e.v);
          chk("fmt_err", int'(fmt_err), e.fmt);
          chk("blk_found", int'(blk_found), e.found);
          chk("blk_x_min", int'(blk_x_min), e.xmin);
          chk("blk_x_max", int'(blk_x_max), e.xmax);
          chk("blk_y_min", int'(blk_y_min), e.ymin);
          chk("blk_y_max", int'(blk_y_max), e.ymax);
          chk("blk_dx", int'($signed(blk_dx)), e.dx);
          chk("blk_dy", int'($signed(blk_dy)), e.dy);
        end
      end
    end
  end

  // Stimulus: directed frames, then randomized ones
  initial begin
    int t;
    idle(5);
    chk("reset_frame_valid", int'(frame_valid), 0);
    chk("reset_h_active", int'(h_active), 0);
    chk("reset_fmt_err", int'(fmt_err), 0);
    chk("reset_blk_found", int'(blk_found), 0);
    rst = 1'b0;
    idle(5);

    set_frame(VD, 1, 10, 5);  send_frame();
    set_frame(VD, 1, 14, 7);  send_frame();
    set_frame(VD, 1, 10, 5);  send_frame();
    set_frame(VD, 0, 0, 0);   send_frame();
    set_frame(VD, 1, 20, 9);  send_frame();
    set_frame(VD, 1, 10, 5);  f_short = 7; f_short_len = 63; send_frame();
    set_frame(31, 1, 30, 20); send_frame();
    set_frame(VD, 1, 10, 5);  f_nx = 9; f_ny = 5; send_frame();
    set_frame(VD, 1, 12, 6);  f_nx = 13; f_ny = 8; send_frame();
    set_frame(0, 0, 0, 0);    send_frame();
    set_frame(VD, 1, 12, 6);  f_rst = 10; send_frame();
    set_frame(VD, 1, 12, 6);  send_frame();
    set_frame(VD, 1, 15, 3);  send_frame();

    for (int i = 0; i < 10; i++) begin
      set_frame((($urandom_range(0, 3) == 0) ? $urandom_range(VD - 1, VD + 1) : VD),
                ($urandom_range(0, 4) != 0) ? 1 : 0,
                $urandom_range(0, HD - 8), $urandom_range(0, VD - 8));
      f_bw = $urandom_range(1, 8);
      f_bh = $urandom_range(1, 8);
      if ($urandom_range(0, 3) == 0) begin
        f_short = $urandom_range(0, f_lines - 1);
        f_short_len = $urandom_range(50, 70);
      end
      if ($urandom_range(0, 2) == 0) begin
        f_nx = $urandom_range(0, HD - 1);
        f_ny = $urandom_range(0, f_lines - 1);
      end
      send_frame();
    end

    vs_pulse();
    idle(10);
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
